// File: rtl/checkpoint_recovery_if.sv
// Recovery request, checkpoint read and restore-write bundle between branch unit, checkpoint buffer and RAT/BP.
// Handshake: a request transfers on a rising edge where bru_recover_valid & bru_recover_ready; the requester holds valid and cpid stable until then.
interface checkpoint_recovery_if #(
  parameter int CPID_W      = 5,
  parameter int PHY_REG_NUM = 64,
  parameter int CHUNK_W     = 16,
  parameter int GHR_W       = 16,
  parameter int LHR_W       = 16
);
  localparam int NCHUNK = PHY_REG_NUM / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic                   bru_recover_valid;
  logic [CPID_W-1:0]      bru_recover_cpid;
  logic                   bru_recover_ready;
  logic [CPID_W-1:0]      exbru_cpbuf_id;
  logic [PHY_REG_NUM-1:0] cpbuf_valid;
  logic [PHY_REG_NUM-1:0] cpbuf_visible;
  logic [GHR_W-1:0]       cpbuf_ghr;
  logic [LHR_W-1:0]       cpbuf_lhr;
  logic                   commit_flush;
  logic                   rat_restore_we;
  logic [IDX_W-1:0]       rat_restore_idx;
  logic [CHUNK_W-1:0]     rat_restore_valid;
  logic [CHUNK_W-1:0]     rat_restore_visible;
  logic                   bp_restore_we;
  logic [GHR_W-1:0]       bp_restore_ghr;
  logic [LHR_W-1:0]       bp_restore_lhr;
  logic                   frontend_flush;
  logic                   recover_done;
  logic [1:0]             dbg_state;

  modport slave (
    input  bru_recover_valid, bru_recover_cpid, cpbuf_valid, cpbuf_visible,
           cpbuf_ghr, cpbuf_lhr, commit_flush,
    output bru_recover_ready, exbru_cpbuf_id, rat_restore_we, rat_restore_idx,
           rat_restore_valid, rat_restore_visible, bp_restore_we, bp_restore_ghr,
           bp_restore_lhr, frontend_flush, recover_done, dbg_state
  );

  modport master (
    output bru_recover_valid, bru_recover_cpid, cpbuf_valid, cpbuf_visible,
           cpbuf_ghr, cpbuf_lhr, commit_flush,
    input  bru_recover_ready, exbru_cpbuf_id, rat_restore_we, rat_restore_idx,
           rat_restore_valid, rat_restore_visible, bp_restore_we, bp_restore_ghr,
           bp_restore_lhr, frontend_flush, recover_done, dbg_state
  );
endinterface

// File: rtl/checkpoint_recovery.sv
// Branch-mispredict recovery sequencer: snapshots a checkpoint, replays RAT bitmaps slice by slice, then history.
// Optional perf counters are enabled by defining CHECKPOINT_RECOVERY_PERF_EN.
module checkpoint_recovery #(
  parameter int CPID_W      = 5,
  parameter int PHY_REG_NUM = 64,
  parameter int CHUNK_W     = 16,
  parameter int GHR_W       = 16,
  parameter int LHR_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  checkpoint_recovery_if.slave         rif
`ifdef CHECKPOINT_RECOVERY_PERF_EN
  ,
  output logic [31:0]                  perf_recover_cnt,
  output logic [31:0]                  perf_busy_cycles
`endif
);
  localparam int NCHUNK = PHY_REG_NUM / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTORE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]             state;
  logic [IDX_W-1:0]       cnt;
  logic [PHY_REG_NUM-1:0] snap_valid;
  logic [PHY_REG_NUM-1:0] snap_visible;
  logic [GHR_W-1:0]       snap_ghr;
  logic [LHR_W-1:0]       snap_lhr;
  logic                   flush_q;
  logic                   accept;
  logic                   restoring;

  assign accept    = (state == S_IDLE) && rif.bru_recover_valid && !rif.commit_flush;
  // A commit flush wins over any restore write issued in the same cycle.
  assign restoring = (state == S_RESTORE) && !rif.commit_flush;

  always_comb begin
    rif.bru_recover_ready   = (state == S_IDLE);
    rif.exbru_cpbuf_id      = ((state == S_IDLE) && rif.bru_recover_valid) ?
                              rif.bru_recover_cpid : '1;
    rif.rat_restore_we      = restoring;
    rif.rat_restore_idx     = cnt;
    rif.rat_restore_valid   = snap_valid[int'(cnt) * CHUNK_W +: CHUNK_W];
    rif.rat_restore_visible = snap_visible[int'(cnt) * CHUNK_W +: CHUNK_W];
    rif.bp_restore_we       = restoring && (cnt == LAST_IDX);
    rif.bp_restore_ghr      = snap_ghr;
    rif.bp_restore_lhr      = snap_lhr;
    rif.frontend_flush      = flush_q;
    rif.recover_done        = (state == S_DONE) && !rif.commit_flush;
    rif.dbg_state           = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      snap_valid   <= '0;
      snap_visible <= '0;
      snap_ghr     <= '0;
      snap_lhr     <= '0;
      flush_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            snap_valid   <= rif.cpbuf_valid;
            snap_visible <= rif.cpbuf_visible;
            snap_ghr     <= rif.cpbuf_ghr;
            snap_lhr     <= rif.cpbuf_lhr;
            cnt          <= '0;
            flush_q      <= 1'b1;
            state        <= S_RESTORE;
          end
        end
        S_RESTORE: begin
          if (rif.commit_flush) begin
            flush_q <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          flush_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          flush_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CHECKPOINT_RECOVERY_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_recover_cnt <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (rif.recover_done && (perf_recover_cnt != 32'hFFFF_FFFF))
        perf_recover_cnt <= perf_recover_cnt + 32'd1;
      if ((state != S_IDLE) && (perf_busy_cycles != 32'hFFFF_FFFF))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_checkpoint_recovery.sv
// Directed bench for checkpoint_recovery: checkpoint-buffer stand-in, cycle model, per-cycle compare and literal pins.
module tb_checkpoint_recovery;
  localparam int CPID_W = 5;
  localparam int PHY    = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = PHY / CHUNK;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [PHY-1:0] cp_valid   [32];
  logic [PHY-1:0] cp_visible [32];
  logic [15:0]    cp_ghr     [32];
  logic [15:0]    cp_lhr     [32];

  checkpoint_recovery_if #(.CPID_W(CPID_W), .PHY_REG_NUM(PHY), .CHUNK_W(CHUNK),
                           .GHR_W(16), .LHR_W(16)) rif ();

`ifdef CHECKPOINT_RECOVERY_PERF_EN
  logic [31:0] perf_recover_cnt;
  logic [31:0] perf_busy_cycles;
`endif

  checkpoint_recovery #(.CPID_W(CPID_W), .PHY_REG_NUM(PHY), .CHUNK_W(CHUNK),
                        .GHR_W(16), .LHR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
`ifdef CHECKPOINT_RECOVERY_PERF_EN
    ,
    .perf_recover_cnt (perf_recover_cnt),
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checkpoint buffer: combinational read on the id the DUT presents
  always_comb begin
    rif.cpbuf_valid   = cp_valid[rif.exbru_cpbuf_id];
    rif.cpbuf_visible = cp_visible[rif.exbru_cpbuf_id];
    rif.cpbuf_ghr     = cp_ghr[rif.exbru_cpbuf_id];
    rif.cpbuf_lhr     = cp_lhr[rif.exbru_cpbuf_id];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot = -1 idle, 0..NCHUNK-1 restoring that slice, NCHUNK completion cycle
  int          m_slot;
  logic [63:0] m_valid, m_visible;
  logic [15:0] m_ghr, m_lhr;
  int          m_done_cnt, m_busy_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_slot = -1; m_valid = '0; m_visible = '0; m_ghr = '0; m_lhr = '0;
      m_done_cnt = 0; m_busy_cnt = 0;
    end else begin
      if (m_slot >= 0) m_busy_cnt++;
      if (m_slot == NCHUNK && !rif.commit_flush) m_done_cnt++;
      if (m_slot < 0) begin
        if (rif.bru_recover_valid && !rif.commit_flush) begin
          m_valid   = cp_valid[rif.bru_recover_cpid];
          m_visible = cp_visible[rif.bru_recover_cpid];
          m_ghr     = cp_ghr[rif.bru_recover_cpid];
          m_lhr     = cp_lhr[rif.bru_recover_cpid];
          m_slot    = 0;
        end
      end else if (rif.commit_flush || m_slot == NCHUNK) begin
        m_slot = -1;
      end else begin
        m_slot = m_slot + 1;
      end
    end
  end

  // Scoreboard compare every cycle
  always @(negedge clk) begin
    logic slice_on;
    slice_on = (m_slot >= 0) && (m_slot < NCHUNK) && !rif.commit_flush;
    check("ready", rif.bru_recover_ready, m_slot < 0);
    check("cpbuf_id", rif.exbru_cpbuf_id,
          (m_slot < 0 && rif.bru_recover_valid) ? rif.bru_recover_cpid : 5'h1f);
    check("rat_we", rif.rat_restore_we, slice_on);
    if (slice_on) begin
      check("rat_idx", rif.rat_restore_idx, m_slot);
      check("rat_valid", rif.rat_restore_valid, (m_valid >> (m_slot * CHUNK)) & 64'hFFFF);
      check("rat_visible", rif.rat_restore_visible, (m_visible >> (m_slot * CHUNK)) & 64'hFFFF);
    end
    check("bp_we", rif.bp_restore_we, slice_on && m_slot == NCHUNK - 1);
    if (slice_on && m_slot == NCHUNK - 1) begin
      check("bp_ghr", rif.bp_restore_ghr, m_ghr);
      check("bp_lhr", rif.bp_restore_lhr, m_lhr);
    end
    check("frontend_flush", rif.frontend_flush, m_slot >= 0);
    check("recover_done", rif.recover_done, m_slot == NCHUNK && !rif.commit_flush);
`ifdef CHECKPOINT_RECOVERY_PERF_EN
    check("perf_recover_cnt", perf_recover_cnt, m_done_cnt);
    check("perf_busy_cycles", perf_busy_cycles, m_busy_cnt);
`endif
  end

  // Driver tasks
  task automatic run_recovery(input logic [4:0] id);
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b1; rif.bru_recover_cpid = id;
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b0;
    repeat (NCHUNK + 1) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [15:0] exp_q[$];
  logic        seen;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    rif.bru_recover_valid = 1'b0;
    rif.bru_recover_cpid  = '0;
    rif.commit_flush      = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cp_valid[i]   = {$urandom, $urandom};
      cp_visible[i] = {$urandom, $urandom};
      cp_ghr[i]     = 16'($urandom_range(0, 65535));
      cp_lhr[i]     = 16'($urandom_range(0, 65535));
    end
    cp_valid[3]   = 64'hF0F0_0000_FFFF_1234;
    cp_visible[3] = 64'h0123_4567_89AB_CDEF;
    cp_ghr[3]     = 16'hABCD;
    cp_lhr[3]     = 16'h5A5A;

    // 1: reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t1_ready", rif.bru_recover_ready, 1);
    check("t1_id", rif.exbru_cpbuf_id, 5'h1f);
    check("t1_rat_we", rif.rat_restore_we, 0);
    check("t1_bp_we", rif.bp_restore_we, 0);
    check("t1_done", rif.recover_done, 0);
    check("t1_flush", rif.frontend_flush, 0);

    // 2: single recovery of checkpoint 3 with literal slice values
    exp_q = '{16'h1234, 16'hFFFF, 16'h0000, 16'hF0F0};
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b1; rif.bru_recover_cpid = 5'd3;
    @(negedge clk);
    check("t2_id_accept", rif.exbru_cpbuf_id, 5'd3);
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b0;
    for (int i = 0; i < NCHUNK; i++) begin
      @(negedge clk);
      check("t2_we", rif.rat_restore_we, 1);
      check("t2_idx", rif.rat_restore_idx, i);
      check("t2_slice", rif.rat_restore_valid, exp_q.pop_front());
      check("t2_bp_we", rif.bp_restore_we, i == NCHUNK - 1);
      if (i == NCHUNK - 1) check("t2_ghr", rif.bp_restore_ghr, 16'hABCD);
    end
    @(negedge clk);
    check("t2_done", rif.recover_done, 1);
    check("t2_flush_done", rif.frontend_flush, 1);
    @(posedge clk); #1;

    // 3: back-to-back with valid held
    rif.bru_recover_valid = 1'b1; rif.bru_recover_cpid = 5'd7;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rif.recover_done) seen = 1'b1;
    end
    check("t3_done_seen", seen, 1);
    @(negedge clk);
    check("t3_ready_after_done", rif.bru_recover_ready, 1);
    check("t3_no_overlap", rif.rat_restore_we, 0);
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b0;
    repeat (NCHUNK + 1) @(posedge clk);
    #1;

    // 4: commit flush on slice 1
    rif.bru_recover_valid = 1'b1; rif.bru_recover_cpid = 5'd3;
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b0;
    @(posedge clk); #1;
    rif.commit_flush = 1'b1;
    @(negedge clk);
    check("t4_we_dropped", rif.rat_restore_we, 0);
    check("t4_flush_held", rif.frontend_flush, 1);
    @(posedge clk); #1;
    rif.commit_flush = 1'b0;
    @(negedge clk);
    check("t4_ready", rif.bru_recover_ready, 1);
    check("t4_ff_low", rif.frontend_flush, 0);
    check("t4_no_done", rif.recover_done, 0);
    repeat (3) @(negedge clk);
    check("t4_no_bp", rif.bp_restore_we, 0);

    // 5: valid blocked by commit flush in idle
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b1; rif.bru_recover_cpid = 5'd9; rif.commit_flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_ready", rif.bru_recover_ready, 1);
      check("t5_ff", rif.frontend_flush, 0);
    end
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b0; rif.commit_flush = 1'b0;
    @(negedge clk);
    check("t5_not_accepted", rif.frontend_flush, 0);

    // Async reset in the middle of a restore
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b1; rif.bru_recover_cpid = 5'd12;
    @(posedge clk); #1;
    rif.bru_recover_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", rif.bru_recover_ready, 1);
    check("rst_ff", rif.frontend_flush, 0);
    check("rst_we", rif.rat_restore_we, 0);
    check("rst_id", rif.exbru_cpbuf_id, 5'h1f);
    @(posedge clk); #1;
    rst = 1'b1;

    // Further recoveries, including the all-ones id
    run_recovery(5'd5);
    run_recovery(5'd31);
    run_recovery(5'd0);

`ifdef CHECKPOINT_RECOVERY_PERF_EN
    // 6: counters after three full recoveries from reset
    apply_reset();
    @(negedge clk);
    check("t6_cnt_reset", perf_recover_cnt, 0);
    run_recovery(5'd3);
    run_recovery(5'd4);
    run_recovery(5'd5);
    @(negedge clk);
    check("t6_recover_cnt", perf_recover_cnt, 32'd3);
    check("t6_busy_cycles", perf_busy_cycles, 32'd15);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
